// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared encodings for the two-master wishbone arbiter
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      OWN0  = 2'b01,
      OWN1  = 2'b10,
      ABORT = 2'b11
   } state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - 8-bit stall counter flagging the last cycle before abort
module wb_watchdog #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic expire
);

   localparam logic [7:0] LAST = 8'(LIMIT - 1);

   logic [7:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= 8'd0;
      end else if (clr) begin
         count <= 8'd0;
      end else if (en) begin
         count <= count + 8'd1;
      end
   end

   assign expire = (count == LAST);

endmodule

// File: rtl/wishbone_arbiter.sv
// rtl/wishbone_arbiter.sv - round-robin two-master, one-slave wishbone arbiter
module wishbone_arbiter
   import wb_arb_pkg::*;
#(
   parameter int AW      = 16,
   parameter int DW      = 8,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_cyc,
   input  logic          m0_stb,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_adr,
   input  logic [DW-1:0] m0_dat_o,
   output logic [DW-1:0] m0_dat_i,
   output logic          m0_ack,
   output logic          m0_err,
   input  logic          m1_cyc,
   input  logic          m1_stb,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_adr,
   input  logic [DW-1:0] m1_dat_o,
   output logic [DW-1:0] m1_dat_i,
   output logic          m1_ack,
   output logic          m1_err,
   output logic          s_cyc,
   output logic          s_stb,
   output logic          s_we,
   output logic [AW-1:0] s_adr,
   output logic [DW-1:0] s_dat_o,
   input  logic [DW-1:0] s_dat_i,
   input  logic          s_ack,
   output logic [1:0]    gnt,
   output logic          busy
);

   state_t state;
   logic   last;
   logic   own_stb;
   logic   wd_en;
   logic   wd_expire;
   logic   stall_out;

   assign own_stb   = (state == OWN0) ? m0_stb : (state == OWN1) ? m1_stb : 1'b0;
   assign wd_en     = own_stb && !s_ack;
   assign stall_out = wd_en && wd_expire;

   wb_watchdog #(.LIMIT(TIMEOUT)) u_wdog (
      .clk    (clk),
      .reset  (reset),
      .en     (wd_en),
      .clr    (!wd_en),
      .expire (wd_expire)
   );

   // A release always passes through IDLE, so tenures never hand over back to back.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         gnt    <= 2'b00;
         last   <= M1;
         busy   <= 1'b0;
         m0_err <= 1'b0;
         m1_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_cyc && (!m1_cyc || last == M1)) begin
                  state <= OWN0;
                  gnt   <= 2'b01;
                  last  <= M0;
                  busy  <= 1'b1;
               end else if (m1_cyc) begin
                  state <= OWN1;
                  gnt   <= 2'b10;
                  last  <= M1;
                  busy  <= 1'b1;
               end
            end
            OWN0: begin
               if (!m0_cyc) begin
                  state <= IDLE;
                  gnt   <= 2'b00;
                  busy  <= 1'b0;
               end else if (stall_out) begin
                  state  <= ABORT;
                  m0_err <= 1'b1;
               end
            end
            OWN1: begin
               if (!m1_cyc) begin
                  state <= IDLE;
                  gnt   <= 2'b00;
                  busy  <= 1'b0;
               end else if (stall_out) begin
                  state  <= ABORT;
                  m1_err <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               gnt    <= 2'b00;
               busy   <= 1'b0;
               m0_err <= 1'b0;
               m1_err <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      s_cyc    = 1'b0;
      s_stb    = 1'b0;
      s_we     = 1'b0;
      s_adr    = '0;
      s_dat_o  = '0;
      m0_ack   = 1'b0;
      m1_ack   = 1'b0;
      m0_dat_i = '0;
      m1_dat_i = '0;
      case (state)
         OWN0: begin
            s_cyc    = m0_cyc;
            s_stb    = m0_stb;
            s_we     = m0_we;
            s_adr    = m0_adr;
            s_dat_o  = m0_dat_o;
            m0_ack   = s_ack;
            m0_dat_i = s_dat_i;
         end
         OWN1: begin
            s_cyc    = m1_cyc;
            s_stb    = m1_stb;
            s_we     = m1_we;
            s_adr    = m1_adr;
            s_dat_o  = m1_dat_o;
            m1_ack   = s_ack;
            m1_dat_i = s_dat_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// tb/tb_wishbone_arbiter.sv - directed scoreboard bench for wishbone_arbiter
module tb_wishbone_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [15:0] m0_adr, m1_adr, s_adr;
   logic [7:0]  m0_dat_o, m1_dat_o, m0_dat_i, m1_dat_i, s_dat_o, s_dat_i;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic        s_cyc, s_stb, s_we, s_ack, busy;
   logic [1:0]  gnt;

   typedef struct packed {
      logic [3:0] flags;
      logic [7:0] d0;
      logic [7:0] d1;
   } resp_t;

   resp_t exp_q[$];
   int    errors = 0;
   int    checks = 0;

   wishbone_arbiter #(.AW(16), .DW(8), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
      .m0_dat_o(m0_dat_o), .m0_dat_i(m0_dat_i), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
      .m1_dat_o(m1_dat_o), .m1_dat_i(m1_dat_i), .m1_ack(m1_ack), .m1_err(m1_err),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i), .s_ack(s_ack), .gnt(gnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_resp(input logic [3:0] flags, input logic [7:0] d0, input logic [7:0] d1);
      resp_t r;
      r.flags = flags;
      r.d0    = d0;
      r.d1    = d1;
      exp_q.push_back(r);
   endtask

   // flags order: {m0_ack, m1_ack, m0_err, m1_err}
   always @(negedge clk) begin
      if (reset && (m0_ack || m1_ack || m0_err || m1_err)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp", {12'd0, m0_ack, m1_ack, m0_err, m1_err, m0_dat_i, m1_dat_i}, 32'd0);
         end else begin
            resp_t e;
            e = exp_q.pop_front();
            check("resp", {12'd0, m0_ack, m1_ack, m0_err, m1_err, m0_dat_i, m1_dat_i}, {12'd0, e});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL sim_timeout: got running expected finished");
      $fatal(1);
   end

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack} = '0;
      m0_adr = '0; m1_adr = '0; m0_dat_o = '0; m1_dat_o = '0; s_dat_i = '0;
      #2;
      check("reset_outputs", {gnt, busy, s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
      tick();
      reset = 1'b1;
      tick();

      // m0 single read, slave acks two cycles after strobe
      m0_cyc = 1; m0_stb = 1; m0_adr = 16'h0012;
      tick();
      #1;
      check("t1_gnt", {gnt, s_stb, busy}, {28'd0, 2'b01, 1'b1, 1'b1});
      check("t1_adr", s_adr, 32'h0012);
      tick();
      tick();
      s_ack = 1; s_dat_i = 8'hA5;
      expect_resp(4'b1000, 8'hA5, 8'h00);
      tick();
      s_ack = 0; s_dat_i = 0; m0_cyc = 0; m0_stb = 0;
      tick();
      #1;
      check("t1_idle", {gnt, busy}, 32'd0);

      // simultaneous requests: round-robin with one idle cycle between tenures
      do_reset();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      tick();
      #1;
      check("t2_first_gnt", gnt, 32'd1);
      s_ack = 1; s_dat_i = 8'h3C;
      expect_resp(4'b1000, 8'h3C, 8'h00);
      tick();
      s_ack = 0; s_dat_i = 0; m0_cyc = 0; m0_stb = 0;
      tick();
      #1;
      check("t2_gap", {gnt, busy}, 32'd0);
      tick();
      #1;
      check("t2_second_gnt", gnt, 32'd2);
      s_ack = 1; s_dat_i = 8'h5A;
      expect_resp(4'b0100, 8'h00, 8'h5A);
      tick();
      s_ack = 0; s_dat_i = 0; m1_cyc = 0; m1_stb = 0;
      tick();

      // m1 holds the bus for three writes while m0 waits
      m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 16'h0100; m1_dat_o = 8'h11;
      tick();
      #1;
      check("t3_gnt_m1", gnt, 32'd2);
      m0_cyc = 1; m0_stb = 1; m0_adr = 16'h0BAD;
      for (int i = 0; i < 3; i++) begin
         m1_adr = 16'h0100 + 16'(i);
         m1_dat_o = 8'h11 * 8'(i + 1);
         s_ack = 1;
         #1;
         check("t3_write", {s_we, s_adr, s_dat_o}, {7'd0, 1'b1, 16'h0100 + 16'(i), 8'h11 * 8'(i + 1)});
         expect_resp(4'b0100, 8'h00, 8'h00);
         tick();
      end
      s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
      tick();
      #1;
      check("t3_gap", gnt, 32'd0);
      tick();
      #1;
      check("t3_gnt_m0", gnt, 32'd1);
      m0_cyc = 0; m0_stb = 0;
      tick();
      tick();

      // watchdog abort after 16 unacknowledged strobe cycles
      m0_cyc = 1; m0_stb = 1;
      tick();
      for (int i = 0; i < 15; i++) tick();
      #1;
      check("t4_cycle16_owned", {gnt, s_cyc, m0_err}, {28'd0, 2'b01, 1'b1, 1'b0});
      expect_resp(4'b0010, 8'h00, 8'h00);
      tick();
      #1;
      check("t4_abort", {gnt, busy, s_cyc, s_stb, m1_err}, {27'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0});
      m0_cyc = 0; m0_stb = 0;
      tick();
      #1;
      check("t4_after", {gnt, busy, m0_err}, 32'd0);

      // ack coincident with expiry wins and clears the counter
      m0_cyc = 1; m0_stb = 1;
      tick();
      for (int i = 0; i < 15; i++) tick();
      s_ack = 1; s_dat_i = 8'h77;
      expect_resp(4'b1000, 8'h77, 8'h00);
      tick();
      s_ack = 0; s_dat_i = 0;
      #1;
      check("t5_no_abort", {gnt, s_cyc, m0_err}, {28'd0, 2'b01, 1'b1, 1'b0});
      for (int i = 0; i < 15; i++) tick();
      #1;
      check("t5_counter_cleared", {gnt, s_cyc, m0_err}, {28'd0, 2'b01, 1'b1, 1'b0});
      m0_cyc = 0; m0_stb = 0;
      tick();
      tick();

      // asynchronous reset in the middle of an m1 tenure
      m1_cyc = 1; m1_stb = 1;
      tick();
      #1;
      check("t6_gnt_m1", gnt, 32'd2);
      reset = 1'b0;
      #1;
      check("t6_async_reset", {gnt, busy, s_cyc, s_stb}, 32'd0);
      tick();
      reset = 1'b1;
      m0_cyc = 1; m0_stb = 1;
      tick();
      #1;
      check("t6_tie_after_reset", gnt, 32'd1);
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      tick();
      tick();

      check("queue_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
